// File: rtl/mux8_pkg.sv
// Shared channel-index encoding for the eight-way collector and distributor.
// Both blocks import this package so that they agree on what each sel value means.
package mux8_pkg;

    localparam int NumCh    = 8;
    localparam int SelWidth = 3;

    typedef enum logic [SelWidth-1:0] {
        SEL_A = 3'd0,
        SEL_B = 3'd1,
        SEL_C = 3'd2,
        SEL_D = 3'd3,
        SEL_E = 3'd4,
        SEL_F = 3'd5,
        SEL_G = 3'd6,
        SEL_H = 3'd7
    } sel_e;

    // Modulo-8 increment; the 3-bit result wraps from 7 back to 0.
    function automatic logic [SelWidth-1:0] next_idx(input logic [SelWidth-1:0] idx);
        return idx + SelWidth'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational eight-way round-robin arbiter.
// It rotates the request vector so that ptr lands at bit 0, picks the lowest set bit, then rotates the index back.
module rr_arbiter8
    import mux8_pkg::*;
(
    input  logic [NumCh-1:0]    req,
    input  logic [SelWidth-1:0] ptr,
    output logic                gnt_valid,
    output logic [SelWidth-1:0] gnt_idx
);

    logic [2*NumCh-1:0]  dbl;
    logic [NumCh-1:0]    rot;
    logic [SelWidth-1:0] off;

    always_comb begin
        dbl       = {req, req} >> ptr;
        rot       = dbl[NumCh-1:0];
        off       = '0;
        gnt_valid = 1'b0;
        // Scanning downward leaves off at the lowest set bit, which is the nearest requester at or after ptr.
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_valid = 1'b1;
                off       = SelWidth'(i);
            end
        end
        gnt_idx = off + ptr;
    end

endmodule

// File: rtl/rr_mux8_collector.sv
// Eight-to-one round-robin collector with a one-entry registered output slot.
// A (sel, value) pair leaves on a valid/ready stream whose sel encoding matches the distributor's.
module rr_mux8_collector
    import mux8_pkg::*;
#(
    parameter int Width = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    a_i,
    input  logic [Width-1:0]    b_i,
    input  logic [Width-1:0]    c_i,
    input  logic [Width-1:0]    d_i,
    input  logic [Width-1:0]    e_i,
    input  logic [Width-1:0]    f_i,
    input  logic [Width-1:0]    g_i,
    input  logic [Width-1:0]    h_i,
    input  logic [NumCh-1:0]    valid_i,
    output logic [NumCh-1:0]    ready_o,
    output logic [SelWidth-1:0] sel_o,
    output logic [Width-1:0]    value_o,
    output logic                valid_o,
    input  logic                ready_i
);

    logic [Width-1:0]    chan [NumCh];
    logic [SelWidth-1:0] ptr;
    logic                gnt_valid;
    logic [SelWidth-1:0] gnt_idx;
    sel_e                gnt_sel;
    logic                slot_free;
    logic                accept;

    assign chan[0] = a_i;
    assign chan[1] = b_i;
    assign chan[2] = c_i;
    assign chan[3] = d_i;
    assign chan[4] = e_i;
    assign chan[5] = f_i;
    assign chan[6] = g_i;
    assign chan[7] = h_i;

    rr_arbiter8 u_arbiter (
        .req       (valid_i),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_sel   = sel_e'(gnt_idx);
    assign slot_free = !valid_o || ready_i;
    assign accept    = slot_free && gnt_valid;

    // ready_o is held low during reset because the emptied slot would otherwise look free.
    always_comb begin
        ready_o = '0;
        if (accept && !rst_i) begin
            ready_o[gnt_idx] = 1'b1;
        end
    end

    // If the slot drains and refills on the same edge, valid_o stays high, which sustains one transfer per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            sel_o   <= '0;
            value_o <= '0;
            ptr     <= '0;
        end else if (accept) begin
            valid_o <= 1'b1;
            sel_o   <= gnt_sel;
            value_o <= chan[gnt_idx];
            ptr     <= next_idx(gnt_idx);
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux8_collector.sv
// Directed bench for rr_mux8_collector: stimulus pushes expected (sel, value) pairs into a queue,
// and a negedge monitor pops and compares them on every output handshake.
module tb_rr_mux8_collector;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] a_i, b_i, c_i, d_i, e_i, f_i, g_i, h_i;
    logic [7:0] valid_i;
    logic [7:0] ready_o;
    logic [2:0] sel_o;
    logic [4:0] value_o;
    logic       valid_o;
    logic       ready_i;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_q [$];

    rr_mux8_collector #(.Width(5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .d_i     (d_i),
        .e_i     (e_i),
        .f_i     (f_i),
        .g_i     (g_i),
        .h_i     (h_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sel_o   (sel_o),
        .value_o (value_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, check the combinational ready_o, optionally queue the pair that this
    // cycle's accept should place in the slot, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic [7:0] v, input logic r, input logic [7:0] exp_rdy,
                                 input logic push, input logic [2:0] s, input logic [4:0] val,
                                 input string name);
        valid_i = v;
        ready_i = r;
        #1;
        checkOutput(name, 32'(ready_o), 32'(exp_rdy));
        if (push) exp_q.push_back({s, val});
        @(posedge clk_i);
        #1;
    endtask

    task automatic setChannels(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                               input logic [4:0] d, input logic [4:0] e, input logic [4:0] f,
                               input logic [4:0] g, input logic [4:0] h);
        a_i = a; b_i = b; c_i = c; d_i = d;
        e_i = e; f_i = f; g_i = g; h_i = h;
    endtask

    // The monitor consumes one expected pair per output handshake, i.e. whenever valid_o and ready_i are high before an edge.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL out_unexpected: got sel %0d value 0x%0h, expected no output", sel_o, value_o);
            end else begin
                logic [7:0] exp;
                exp = exp_q.pop_front();
                checkOutput("out_sel", 32'(sel_o), 32'(exp[7:5]));
                checkOutput("out_value", 32'(value_o), 32'(exp[4:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 8'hFF;
        ready_i = 1'b0;
        setChannels(5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08);
        #2;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_sel", 32'(sel_o), 32'd0);
        checkOutput("rst_value", 32'(value_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd0);
        valid_i = 8'h00;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset mid-stream: the slot loaded with d = 0x1F is discarded, and the search restarts at a.
        setChannels(5'h03, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1C);
        applyStimulus(8'h08, 1'b0, 8'h08, 1'b0, 3'd0, 5'h00, "t1_load_ready");
        checkOutput("t1_loaded_valid", 32'(valid_o), 32'd1);
        checkOutput("t1_loaded_value", 32'(value_o), 32'h1F);
        #2;
        rst_i   = 1'b1;
        valid_i = 8'h81;
        ready_i = 1'b1;
        #1;
        checkOutput("t1_async_valid", 32'(valid_o), 32'd0);
        checkOutput("t1_async_sel", 32'(sel_o), 32'd0);
        checkOutput("t1_async_value", 32'(value_o), 32'd0);
        checkOutput("t1_async_ready", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 5'h03, "t1_first_is_a");
        applyStimulus(8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 5'h1C, "t1_then_h");
        applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 5'h00, "t1_idle");
        checkOutput("t1_drained", 32'(valid_o), 32'd0);

        // All channels valid: sel 0..7 then 0 with no bubbles.
        setChannels(5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1, 3'(k % 8), 5'((k % 8) + 1), "t3_ready");
            checkOutput("t3_no_bubble", 32'(valid_o), 32'd1);
        end
        applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 5'h00, "t3_idle");
        checkOutput("t3_drained", 32'(valid_o), 32'd0);

        // Single channel c.
        setChannels(5'h00, 5'h00, 5'h15, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        applyStimulus(8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 5'h15, "t2_ready_c");
        checkOutput("t2_sel", 32'(sel_o), 32'd2);
        checkOutput("t2_value", 32'(value_o), 32'h15);
        checkOutput("t2_valid", 32'(valid_o), 32'd1);
        applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 5'h00, "t2_idle");
        checkOutput("t2_drained", 32'(valid_o), 32'd0);

        // Backpressure on sel 3 / 0x0A, then release to e.
        setChannels(5'h01, 5'h02, 5'h03, 5'h0A, 5'h0B, 5'h06, 5'h07, 5'h08);
        applyStimulus(8'hFF, 1'b0, 8'h08, 1'b1, 3'd3, 5'h0A, "t4_load_d");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 5'h00, "t4_stall_ready");
            checkOutput("t4_hold_valid", 32'(valid_o), 32'd1);
            checkOutput("t4_hold_sel", 32'(sel_o), 32'd3);
            checkOutput("t4_hold_value", 32'(value_o), 32'h0A);
        end
        applyStimulus(8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 5'h0B, "t4_release");
        checkOutput("t4_next_sel", 32'(sel_o), 32'd4);

        // After e: b and f valid -> f then b.
        setChannels(5'h01, 5'h09, 5'h03, 5'h0A, 5'h0B, 5'h16, 5'h07, 5'h08);
        applyStimulus(8'h22, 1'b1, 8'h20, 1'b1, 3'd5, 5'h16, "t6_f_first");
        applyStimulus(8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 5'h09, "t6_then_b");
        applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 5'h00, "t6_idle");
        checkOutput("t6_drained", 32'(valid_o), 32'd0);

        // Wrap: after h, a and h valid -> a then h.
        setChannels(5'h11, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1E);
        applyStimulus(8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 5'h1E, "t5_grant_h");
        applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 5'h11, "t5_wrap_a");
        applyStimulus(8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 5'h1E, "t5_then_h");
        applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 5'h00, "t5_idle");
        applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 5'h00, "t5_idle2");
        checkOutput("t5_drained", 32'(valid_o), 32'd0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
